seg_scan_mux: RTL



---
 rtl/seg_scan_mux.sv | 108 ++++++++++
 1 files changed

// File: rtl/seg_scan_mux.sv
// Scan controller for an 8-digit common-anode seven-segment display: one nibble per slot,
// blanking gap per slot, optional leading-zero suppression and frame-synchronous value updates.
//
// state    | meaning
// ---------+--------------------------------------------------------
// ST_BLANK | first BLANK_CYCLES of a slot, all anodes off
// ST_ON    | rest of the slot, current digit lit if visible
module seg_scan_mux #(
  parameter int REFRESH_DIV      = 50000,
  parameter int BLANK_CYCLES     = 1000,
  parameter bit ANODE_ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] value,
  input  logic        load,
  input  logic        blank_lz,
  input  logic [7:0]  digit_mask,
  output logic [3:0]  nibble,
  output logic [7:0]  an,
  output logic [2:0]  digit_idx,
  output logic        frame_done
);

  localparam int              CW      = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0]   CNT_MAX = CW'(REFRESH_DIV - 1);
  localparam logic [7:0]      AN_OFF  = ANODE_ACTIVE_LOW ? 8'hFF : 8'h00;

  typedef enum logic {ST_BLANK, ST_ON} state_t;
  localparam state_t ST_RST = (BLANK_CYCLES > 0) ? ST_BLANK : ST_ON;

  state_t         state, state_n;
  logic [CW-1:0]  cnt, cnt_n;
  logic [2:0]     idx_n, msd;
  logic [31:0]    shadow, shadow_n, pending, pending_n;
  logic           pending_valid, pv_n;
  logic           slot_end, wrap, visible;
  logic [3:0]     nibble_n;
  logic [7:0]     an_n;
  logic           fd_n;

  always_comb begin
    slot_end  = (cnt == CNT_MAX);
    wrap      = slot_end && (digit_idx == 3'd7);
    cnt_n     = slot_end ? '0 : cnt + 1'b1;
    idx_n     = slot_end ? digit_idx + 3'd1 : digit_idx;

    // A load landing on the boundary edge bypasses pending entirely.
    shadow_n  = shadow;
    pending_n = pending;
    pv_n      = pending_valid;
    if (load) begin
      if (wrap) begin
        shadow_n = value;
      end else begin
        pending_n = value;
        pv_n      = 1'b1;
      end
    end
    if (wrap) begin
      pv_n = 1'b0;
      if (!load && pending_valid) shadow_n = pending;
    end

    state_n = state;
    case (state)
      ST_BLANK: if (32'(cnt_n) >= BLANK_CYCLES) state_n = ST_ON;
      ST_ON:    if (slot_end && (BLANK_CYCLES > 0)) state_n = ST_BLANK;
      default:  state_n = ST_RST;
    endcase

    msd = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (shadow_n[4*i +: 4] != 4'h0) msd = 3'(i);
    end

    visible  = digit_mask[idx_n] && (!blank_lz || (idx_n <= msd));
    nibble_n = shadow_n[{idx_n, 2'b00} +: 4];
    an_n     = AN_OFF;
    if ((state_n == ST_ON) && visible) an_n[idx_n] = ~ANODE_ACTIVE_LOW;
    fd_n     = (idx_n == 3'd7) && (cnt_n == CNT_MAX);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_RST;
      cnt           <= '0;
      digit_idx     <= 3'd0;
      shadow        <= 32'h0;
      pending       <= 32'h0;
      pending_valid <= 1'b0;
      nibble        <= 4'h0;
      an            <= AN_OFF;
      frame_done    <= 1'b0;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      digit_idx     <= idx_n;
      shadow        <= shadow_n;
      pending       <= pending_n;
      pending_valid <= pv_n;
      nibble        <= nibble_n;
      an            <= an_n;
      frame_done    <= fd_n;
    end
  end

endmodule
